client_arbiter: RTL and testbench
=================================

CLIENT_ARBITER -- requirements
Module: client_arbiter

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 1 bit.
REQ-002 clock  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 priority_sel  input  1  priority select: 0 = client1 wins contention, 1 = client2 wins contention.
REQ-005 client1_req  input  1  level request from client 1.
REQ-006 client2_req  input  1  level request from client 2.
REQ-007 o_grant1  output  1  registered grant to client 1.
REQ-008 o_grant2  output  1  registered grant to client 2.

Function
REQ-009 The block SHALL implement a 3-state FSM: IDLE (no grant), GNT1 (o_grant1=1), GNT2 (o_grant2=1).
REQ-010 Outputs SHALL decode directly from state registers, so outputs are glitch-free with no combinational path from inputs.
REQ-011 Next state SHALL be evaluated every cycle from the current inputs only, with no lock and no grant hold.
  - No requests -> IDLE.
  - Only client1_req -> GNT1.
  - Only client2_req -> GNT2.
  - Both requests, priority_sel=0 -> GNT1.
  - Both requests, priority_sel=1 -> GNT2.
REQ-012 Latency SHALL be exactly one clock: inputs sampled at edge N appear on the grants after edge N.
REQ-013 o_grant1 and o_grant2 SHALL never be 1 simultaneously in any cycle.
REQ-014 A request dropped at edge N SHALL remove its grant after edge N.
  - If the other client is requesting, the grant SHALL transfer directly to it with no IDLE cycle.
REQ-015 A priority_sel change while both clients request SHALL move the grant to the newly favoured client on the next edge (preemption).
REQ-016 priority_sel SHALL have no effect when at most one client requests.
REQ-017 Unreachable state encodings SHALL recover to IDLE on the next edge.

Reset
REQ-018 While reset_n=0, the state SHALL be IDLE and o_grant1=o_grant2=0, asynchronously and immediately.
REQ-019 Reset asserted mid-grant SHALL drop the grant immediately without waiting for a clock edge.
REQ-020 After reset_n deasserts, the first arbitration SHALL occur on the first rising edge.
  - Requests already held high during reset SHALL be granted after that edge.

Structure
REQ-021 The state enumeration (IDLE/GNT1/GNT2, 2-bit encoding) SHALL live in a shared arbiter package; no other constants are required.
REQ-022 Implementation SHALL consist of a single module with three parts and no sub-modules:
  - a sequential state register;
  - a combinational next-state block;
  - an output decode block.

Verification
REQ-023 Reset with client1_req=client2_req=1 -> o_grant1=0, o_grant2=0 for the whole reset; grant1 after the first edge post-release if priority_sel=0.
REQ-024 No requests, reset released -> o_grant1=0, o_grant2=0 on every cycle.
REQ-025 client1_req=1, client2_req=0, priority_sel=0 -> o_grant1=1, o_grant2=0 one edge later.
REQ-026 client1_req=0, client2_req=1, priority_sel=1 -> o_grant1=0, o_grant2=1 one edge later; the same result with priority_sel=0.
REQ-027 Contention sequence:
  - Both requests with priority_sel=0 -> o_grant1=1, o_grant2=0.
  - priority_sel then set to 1 -> o_grant1=0, o_grant2=1 after the next edge.
REQ-028 Random requests and priority_sel over 1000 cycles -> grants never both 1, and each grant matches the REQ-011 table applied to the inputs of the previous edge.

Source files
------------

// File: rtl/client_arbiter_pkg.sv
// Shared state encoding for the two-client arbiter.
package client_arbiter_pkg;

  localparam logic [1:0] StIdle = 2'b00;
  localparam logic [1:0] StGnt1 = 2'b01;
  localparam logic [1:0] StGnt2 = 2'b10;

endpackage

// File: rtl/client_arbiter.sv
// Two-client arbiter with selectable fixed priority. Grants are re-evaluated every cycle
// from the current requests and come straight from the state register.
module client_arbiter
  import client_arbiter_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic priority_sel,
  input  logic client1_req,
  input  logic client2_req,
  output logic o_grant1,
  output logic o_grant2
);

  logic [1:0] state_q;
  logic [1:0] state_d;

  // State register; reset forces IDLE immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state depends only on this cycle's inputs, so an illegal encoding
  // is also replaced on the next edge.
  always_comb begin
    state_d = StIdle;
    unique case ({client1_req, client2_req})
      2'b00: state_d = StIdle;
      2'b10: state_d = StGnt1;
      2'b01: state_d = StGnt2;
      2'b11: state_d = priority_sel ? StGnt2 : StGnt1;
      default: state_d = StIdle;
    endcase
  end

  // Output decode; the unused encoding grants nothing.
  always_comb begin
    o_grant1 = (state_q == StGnt1);
    o_grant2 = (state_q == StGnt2);
  end

endmodule

// File: tb/tb_client_arbiter.sv
// Self-checking bench for client_arbiter: vector table, directed corner sequences,
// and a randomized run against a reference model.
module tb_client_arbiter;

  logic clock;
  logic reset_n;
  logic priority_sel;
  logic client1_req;
  logic client2_req;
  logic o_grant1;
  logic o_grant2;

  int n_pass;
  int n_total;

  typedef struct {
    logic psel;
    logic r1;
    logic r2;
    logic g1;
    logic g2;
  } vec_t;

  vec_t vecs[10];

  client_arbiter dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .priority_sel(priority_sel),
    .client1_req (client1_req),
    .client2_req (client2_req),
    .o_grant1    (o_grant1),
    .o_grant2    (o_grant2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic exp_g1, input logic exp_g2);
    n_total++;
    if (o_grant1 === exp_g1 && o_grant2 === exp_g2) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got g1=%b g2=%b, expected g1=%b g2=%b", name, o_grant1, o_grant2,
               exp_g1, exp_g2);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic psel, input logic r1, input logic r2);
    priority_sel = psel;
    client1_req  = r1;
    client2_req  = r2;
  endtask

  // Reference arbitration table: returns {g1, g2}.
  function automatic logic [1:0] model(input logic psel, input logic r1, input logic r2);
    if (r1 && r2) return psel ? 2'b01 : 2'b10;
    if (r1) return 2'b10;
    if (r2) return 2'b01;
    return 2'b00;
  endfunction

  initial begin
    logic [1:0] exp;
    n_pass  = 0;
    n_total = 0;

    vecs[0] = '{psel: 1'b0, r1: 1'b0, r2: 1'b0, g1: 1'b0, g2: 1'b0};
    vecs[1] = '{psel: 1'b0, r1: 1'b1, r2: 1'b0, g1: 1'b1, g2: 1'b0};
    vecs[2] = '{psel: 1'b1, r1: 1'b0, r2: 1'b1, g1: 1'b0, g2: 1'b1};
    vecs[3] = '{psel: 1'b0, r1: 1'b0, r2: 1'b1, g1: 1'b0, g2: 1'b1};
    vecs[4] = '{psel: 1'b1, r1: 1'b1, r2: 1'b0, g1: 1'b1, g2: 1'b0};
    vecs[5] = '{psel: 1'b0, r1: 1'b1, r2: 1'b1, g1: 1'b1, g2: 1'b0};
    vecs[6] = '{psel: 1'b1, r1: 1'b1, r2: 1'b1, g1: 1'b0, g2: 1'b1};
    vecs[7] = '{psel: 1'b1, r1: 1'b0, r2: 1'b0, g1: 1'b0, g2: 1'b0};
    vecs[8] = '{psel: 1'b0, r1: 1'b1, r2: 1'b1, g1: 1'b1, g2: 1'b0};
    vecs[9] = '{psel: 1'b0, r1: 1'b0, r2: 1'b0, g1: 1'b0, g2: 1'b0};

    // Reset held with both clients requesting: no grant on any cycle.
    reset_n = 1'b0;
    drive(1'b0, 1'b1, 1'b1);
    #1;
    check("reset_initial", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_held", 1'b0, 1'b0);
    end
    reset_n = 1'b1;
    #1;
    check("reset_release_no_edge", 1'b0, 1'b0);
    step();
    check("first_edge_after_reset", 1'b1, 1'b0);

    // Idle after reset: no requests, nothing granted.
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_no_req", 1'b0, 1'b0);
    end

    // Table-driven single-edge checks.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].psel, vecs[i].r1, vecs[i].r2);
      #1;
      step();
      check($sformatf("vec%0d", i), vecs[i].g1, vecs[i].g2);
    end

    // Latency is one edge: input change alone does not move the grant.
    drive(1'b0, 1'b1, 1'b0);
    step();
    check("lat_setup", 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    #2;
    check("lat_before_edge", 1'b1, 1'b0);
    step();
    check("lat_after_edge", 1'b0, 1'b1);

    // Dropping a request transfers directly to the other client.
    drive(1'b0, 1'b1, 1'b1);
    step();
    check("xfer_hold1", 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    step();
    check("xfer_to2", 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    step();
    check("xfer_to1", 1'b1, 1'b0);

    // Preemption by priority flip under contention.
    drive(1'b0, 1'b1, 1'b1);
    step();
    check("preempt_before", 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    step();
    check("preempt_to2", 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    step();
    check("preempt_back1", 1'b1, 1'b0);

    // Asynchronous reset mid-grant, then requests held through reset.
    drive(1'b1, 1'b0, 1'b1);
    step();
    check("pre_async_grant", 1'b0, 1'b1);
    reset_n = 1'b0;
    #1;
    check("async_reset_drop", 1'b0, 1'b0);
    step();
    check("async_reset_hold", 1'b0, 1'b0);
    reset_n = 1'b1;
    step();
    check("post_reset_regrant", 1'b0, 1'b1);

    // Random traffic against the reference table.
    for (int i = 0; i < 1000; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      exp = model(priority_sel, client1_req, client2_req);
      step();
      check("random", exp[1], exp[0]);
      if (o_grant1 === 1'b1 && o_grant2 === 1'b1) begin
        $display("FAIL mutex: got g1=%b g2=%b, expected at most one grant", o_grant1, o_grant2);
        n_total++;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
